// File: rtl/vector_result_packer_pkg.sv
// vector_result_packer_pkg: shared widths, SEW encodings and packer state encodings
package vector_result_packer_pkg;
    localparam int LONGEST_LEN      = 64;
    localparam int VECTOR_SIZE      = 8;
    localparam int ENTRY_INDEX_SIZE = 3;
    localparam int LANE_INDEX_SIZE  = 1;
    localparam int LANE_NUM         = 1 << LANE_INDEX_SIZE;
    localparam int VLEN             = VECTOR_SIZE * LONGEST_LEN;
    localparam logic [2:0] ONE_BYTE   = 3'b000;
    localparam logic [2:0] TWO_BYTE   = 3'b001;
    localparam logic [2:0] FOUR_BYTE  = 3'b010;
    localparam logic [2:0] EIGHT_BYTE = 3'b011;
    typedef enum logic [1:0] {PACK_IDLE, PACK_COLLECT, PACK_WB} pack_state_t;
    function automatic logic sew_legal(input logic [2:0] sew);
        return !sew[2];
    endfunction
endpackage

// File: rtl/vector_result_packer_if.sv
// vector_result_packer_if: start/config, lane result and write-back signals of the packer
//   master: drives start, vl, vsew, is_mask_operation, old_vd, lane_*, wb_ready
//   slave:  drives lane_ready, wb_valid, wb_data, done, busy, error
interface vector_result_packer_if;
    import vector_result_packer_pkg::*;
    logic                            start;
    logic [ENTRY_INDEX_SIZE:0]       vl;
    logic [2:0]                      vsew;
    logic                            is_mask_operation;
    logic [VLEN-1:0]                 old_vd;
    logic [LANE_NUM-1:0]             lane_valid;
    logic [LANE_NUM-1:0]             lane_active;
    logic [LANE_NUM*LONGEST_LEN-1:0] lane_result;
    logic                            lane_ready;
    logic                            wb_valid;
    logic [VLEN-1:0]                 wb_data;
    logic                            wb_ready;
    logic                            done;
    logic                            busy;
    logic                            error;
    modport master (
        output start, vl, vsew, is_mask_operation, old_vd, lane_valid, lane_active, lane_result, wb_ready,
        input  lane_ready, wb_valid, wb_data, done, busy, error
    );
    modport slave (
        input  start, vl, vsew, is_mask_operation, old_vd, lane_valid, lane_active, lane_result, wb_ready,
        output lane_ready, wb_valid, wb_data, done, busy, error
    );
endinterface

// File: rtl/vector_element_merge.sv
// vector_element_merge: writes one lane result into a vector line at the element slot for the SEW
//   buffer_in/buffer_out: line before/after; idx: element index; vsew, is_mask: placement;
//   active: write enable; result: lane result (only the low SEW bits, or bit 0 for masks, are used)
module vector_element_merge
    import vector_result_packer_pkg::*;
(
    input  logic [VLEN-1:0]             buffer_in,
    input  logic [ENTRY_INDEX_SIZE-1:0] idx,
    input  logic [2:0]                  vsew,
    input  logic                        is_mask,
    input  logic                        active,
    input  logic [LONGEST_LEN-1:0]      result,
    output logic [VLEN-1:0]             buffer_out
);
    always_comb begin
        buffer_out = buffer_in;
        if (active && is_mask) buffer_out[{6'd0, idx}] = result[0];
        else if (active && vsew == ONE_BYTE) buffer_out[{3'd0, idx, 3'd0} +: 8] = result[7:0];
        else if (active && vsew == TWO_BYTE) buffer_out[{2'd0, idx, 4'd0} +: 16] = result[15:0];
        else if (active && vsew == FOUR_BYTE) buffer_out[{1'd0, idx, 5'd0} +: 32] = result[31:0];
        else if (active && vsew == EIGHT_BYTE) buffer_out[{idx, 6'd0} +: 64] = result;
    end
endmodule

// File: rtl/vector_result_packer.sv
// vector_result_packer: assembles lane ALU results into one vector line for register write-back
//   clk, rst: clock and synchronous active-high reset
//   bus (slave): start/vl/vsew/is_mask_operation/old_vd config, lane_valid/active/result in,
//                lane_ready, wb_valid/wb_data/wb_ready write-back, done/busy/error status
module vector_result_packer
    import vector_result_packer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    vector_result_packer_if.slave bus
);
    pack_state_t               state, state_nxt;
    logic [ENTRY_INDEX_SIZE:0] count, count_plus1, count_nxt, vl_q;
    logic [2:0]                vsew_q;
    logic                      mask_q, done_q, error_q;
    logic [VLEN-1:0]           buffer, merged0, merged1;
    logic                      take0, take1, start_ok, start_empty, start_bad;

    assign start_ok    = state == PACK_IDLE && bus.start && sew_legal(bus.vsew) && bus.vl != 0;
    assign start_empty = state == PACK_IDLE && bus.start && sew_legal(bus.vsew) && bus.vl == 0;
    assign start_bad   = state == PACK_IDLE && bus.start && !sew_legal(bus.vsew);
    assign count_plus1 = count + 1'b1;
    // Lane 1 only counts together with lane 0; pattern 10 takes nothing.
    assign take0     = state == PACK_COLLECT && bus.lane_valid[0] && count < vl_q;
    assign take1     = state == PACK_COLLECT && &bus.lane_valid && count_plus1 < vl_q;
    assign count_nxt = count + {3'd0, take0} + {3'd0, take1};

    vector_element_merge merge0 (
        .buffer_in (buffer),
        .idx       (count[ENTRY_INDEX_SIZE-1:0]),
        .vsew      (vsew_q),
        .is_mask   (mask_q),
        .active    (take0 && bus.lane_active[0]),
        .result    (bus.lane_result[LONGEST_LEN-1:0]),
        .buffer_out(merged0)
    );

    vector_element_merge merge1 (
        .buffer_in (merged0),
        .idx       (count_plus1[ENTRY_INDEX_SIZE-1:0]),
        .vsew      (vsew_q),
        .is_mask   (mask_q),
        .active    (take1 && bus.lane_active[1]),
        .result    (bus.lane_result[2*LONGEST_LEN-1:LONGEST_LEN]),
        .buffer_out(merged1)
    );

    always_comb begin
        state_nxt      = state;
        bus.lane_ready = state == PACK_COLLECT;
        bus.wb_valid   = state == PACK_WB;
        bus.busy       = state != PACK_IDLE;
        case (state)
            PACK_IDLE:    state_nxt = start_ok ? PACK_COLLECT : PACK_IDLE;
            PACK_COLLECT: state_nxt = count_nxt == vl_q ? PACK_WB : PACK_COLLECT;
            PACK_WB:      state_nxt = bus.wb_ready ? PACK_IDLE : PACK_WB;
            default:      state_nxt = PACK_IDLE;
        endcase
    end

    assign bus.wb_data = buffer;
    assign bus.done    = done_q;
    assign bus.error   = error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PACK_IDLE;
            count   <= '0;
            vl_q    <= '0;
            vsew_q  <= ONE_BYTE;
            mask_q  <= 1'b0;
            buffer  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            done_q  <= start_empty || (state == PACK_WB && bus.wb_ready);
            error_q <= start_bad || (state == PACK_COLLECT && bus.lane_valid == 2'b10);
            if (start_ok) begin
                // vl beyond one line's worth of elements is clamped to the line size
                vl_q   <= bus.vl > 4'(VECTOR_SIZE) ? 4'(VECTOR_SIZE) : bus.vl;
                vsew_q <= bus.vsew;
                mask_q <= bus.is_mask_operation;
                buffer <= bus.old_vd;
                count  <= '0;
            end else if (state == PACK_COLLECT) begin
                buffer <= merged1;
                count  <= count_nxt;
            end
        end
    end
endmodule
